solitaire_ctrl: RTL
===================

Name: solitaire_ctrl

Overview:
User-input sequencer for the 7x7 peg-solitaire board datapath (cross-shaped board, centre hole at reset, 32 pegs).
- Debounces five push-buttons and moves a cursor over the existing board spaces.
- Arms a selected peg, then presents exactly one move request (piece_x/piece_y/direction) to the board for one cycle.
- Checks the board's piece_count to classify the move as accepted or rejected, and handles game-over and restart.
- Sits between the top-level IO pins and the board.

Parameters:
- DEBOUNCE_CYCLES, 16, consecutive high samples needed before a button press is recognised (min 1).
- BOARD_WIDTH, 7, board edge length. Only 7 is supported.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- btn_up, btn_down, btn_left, btn_right, btn_sel  in  1 each  already-synchronised raw button levels
- piece_count  in  6  board peg count
- game_over  in  1  board reports no legal move
- piece_x  out  3  column of the move request to the board
- piece_y  out  3  row of the move request to the board
- direction  out  2  move direction to the board: LEFT=00, RIGHT=01, UP=10, DOWN=11
- cursor_x, cursor_y  out  3 each  current cursor position
- armed  out  1  a peg is selected and the block is waiting for a direction
- move_ok  out  1  one-cycle pulse: last move was accepted
- move_bad  out  1  one-cycle pulse: last move was rejected
- move_total  out  5  accepted moves since reset; saturates at 31
- over  out  1  game-over state
- restart_req  out  1  one-cycle pulse asking the top level to reset the board

Behaviour:
- One clock domain. Reset is synchronous and active-high (rst); clock and reset port names are clk and rst.
- Reset values: cursor (3,3), piece_x=0, piece_y=0, direction=00; armed, move_ok, move_bad, over and restart_req all 0; move_total=0; debouncers cleared; FSM in NAV.
- Parking rule: outside the ISSUE state, piece_x/piece_y are held at (0,0). (0,0) is a nonexistent corner, so the board never sees a legal move there.
- Debounce, per button:
  - A counter increments while the input is high and clears when it is low.
  - A one-cycle press event fires on the cycle the count reaches DEBOUNCE_CYCLES.
  - No further event fires until the input has been low for at least one cycle.
  - The event is registered, so it asserts DEBOUNCE_CYCLES cycles after the first high sample.
- Event priority when several events occur in the same cycle: sel > up > down > left > right. Lower-priority events in that cycle are discarded.
- FSM states: NAV, ARMED, ISSUE, CHECK, OVER.
- NAV:
  - A direction event moves the cursor one step: up is y-1, down is y+1, left is x-1, right is x+1.
  - The step is taken only if the target lies inside 0..6 and is an existing space (the cross: x in 2..4 or y in 2..4). Otherwise the cursor holds.
  - sel -> ARMED.
  - If game_over=1 and no event is pending -> OVER.
- ARMED (armed=1):
  - sel -> NAV (cancel).
  - A direction event latches the direction, captures piece_count, and -> ISSUE.
- ISSUE:
  - Lasts exactly one cycle.
  - Drives piece_x=cursor_x, piece_y=cursor_y and direction=latched direction.
  - The board samples the request at the end of this cycle.
  - -> CHECK.
- CHECK:
  - Lasts exactly one cycle.
  - If piece_count == captured-1: the move is accepted.
    - move_ok pulses the next cycle.
    - move_total increments (saturating at 31).
    - The cursor moves to the landing square (two steps in the move direction).
  - Otherwise: move_bad pulses and the cursor is unchanged.
  - -> NAV.
- OVER (over=1):
  - sel pulses restart_req for one cycle; the block stays in OVER.
  - When game_over=0: cursor returns to (3,3), move_total clears, -> NAV.
- All button events arriving during ISSUE and CHECK are dropped.
- rst asserted in any state, including ISSUE, returns every register to its reset value on the next edge.

Decomposition:
- Package solitaire_pkg holds:
  - direction localparams (LEFT/RIGHT/UP/DOWN)
  - BOARD_WIDTH
  - the 49-bit SPACE_EXISTS mask
  - the FSM state enum
  - CENTRE=3
- One sub-module, solitaire_debounce (parameter DEBOUNCE_CYCLES; ports clk, rst, in, press). It is instantiated five times.

Test Plan (DEBOUNCE_CYCLES=2, board model attached):
- Reset release -> cursor (3,3), piece_x/y=(0,0), move_total=0, over=0. btn_right held 1 cycle then released -> no cursor move. Held 3 cycles -> cursor (4,3), exactly one step.
- From (3,3): up, up -> (3,1). Left then gives (2,1); a second left is blocked at (2,1) because (1,1) does not exist. Up from (3,0) stays at (3,0).
- Cursor (3,1), sel, then down -> piece_x/y=(3,1) and direction=11 for exactly one cycle. Next cycle piece_count=31, move_ok=1, move_total=1, cursor (3,3).
- Repeat the same down move from (3,1) (now empty) -> move_bad=1, piece_count stays 31, cursor stays (3,1).
- sel and left events in the same cycle in NAV -> ARMED with the cursor unmoved. sel again -> armed=0.
- Force game_over=1 in NAV -> over=1. sel -> restart_req pulses once. Drop game_over -> NAV with cursor (3,3) and move_total=0. Asserting rst during ISSUE -> the next cycle equals the reset values.

Source files
------------

// File: rtl/solitaire_pkg.sv
// Shared constants, board geometry and FSM state type for the peg-solitaire input sequencer.
package solitaire_pkg;

    localparam logic [1:0] DIR_LEFT  = 2'b00;
    localparam logic [1:0] DIR_RIGHT = 2'b01;
    localparam logic [1:0] DIR_UP    = 2'b10;
    localparam logic [1:0] DIR_DOWN  = 2'b11;

    localparam int unsigned BOARD_WIDTH = 7;
    localparam logic [2:0]  CENTRE      = 3'd3;

    // Bit (y*7 + x) is set where the cross-shaped board has a space; row 6 is the top slice.
    localparam logic [48:0] SPACE_EXISTS = {
        7'b0011100, 7'b0011100, 7'b1111111, 7'b1111111,
        7'b1111111, 7'b0011100, 7'b0011100
    };

    typedef enum logic [2:0] {
        StNav,
        StArmed,
        StIssue,
        StCheck,
        StOver
    } state_e;

    function automatic logic space_exists(input logic [3:0] x, input logic [3:0] y);
        logic [5:0] idx;
        if (x >= 4'(BOARD_WIDTH) || y >= 4'(BOARD_WIDTH)) begin
            return 1'b0;
        end
        idx = {2'b00, y} * 6'd7 + {2'b00, x};
        return SPACE_EXISTS[idx];
    endfunction

endpackage

// File: rtl/solitaire_debounce.sv
// Single push-button debouncer: one registered press event per sustained high level.
module solitaire_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic in,
    output logic press
);

    localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          press_q, press_d;

    // Count saturates at the threshold so only a low sample can re-arm the event.
    always_comb begin
        cnt_d   = cnt_q;
        press_d = 1'b0;
        if (!in) begin
            cnt_d = '0;
        end else if (cnt_q != CW'(DEBOUNCE_CYCLES)) begin
            cnt_d   = cnt_q + CW'(1);
            press_d = (cnt_q == CW'(DEBOUNCE_CYCLES - 1));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= '0;
            press_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            press_q <= press_d;
        end
    end

    assign press = press_q;

endmodule

// File: rtl/solitaire_ctrl.sv
// Button-driven move sequencer for the peg-solitaire board: cursor, arm, issue, check, game over.
module solitaire_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned BOARD_WIDTH     = 7
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_sel,
    input  logic [5:0] piece_count,
    input  logic       game_over,
    output logic [2:0] piece_x,
    output logic [2:0] piece_y,
    output logic [1:0] direction,
    output logic [2:0] cursor_x,
    output logic [2:0] cursor_y,
    output logic       armed,
    output logic       move_ok,
    output logic       move_bad,
    output logic [4:0] move_total,
    output logic       over,
    output logic       restart_req
);
    import solitaire_pkg::*;

    logic [4:0] btn_raw, press;
    assign btn_raw = {btn_sel, btn_right, btn_left, btn_down, btn_up};

    for (genvar i = 0; i < 5; i++) begin : g_btn
        solitaire_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debounce (
            .clk  (clk),
            .rst  (rst),
            .in   (btn_raw[i]),
            .press(press[i])
        );
    end

    state_e     state_q, state_d;
    logic [2:0] cur_x_q, cur_x_d, cur_y_q, cur_y_d;
    logic [1:0] dir_q, dir_d;
    logic [5:0] cap_q, cap_d;
    logic [4:0] total_q, total_d;
    logic       ok_q, ok_d, bad_q, bad_d, restart_q, restart_d;

    // sel > up > down > left > right; losers in the same cycle are discarded.
    logic       ev_sel, ev_dir_vld;
    logic [1:0] ev_dir;
    always_comb begin
        ev_sel     = press[4];
        ev_dir_vld = 1'b0;
        ev_dir     = DIR_LEFT;
        if (!ev_sel) begin
            if (press[0]) begin
                ev_dir_vld = 1'b1;
                ev_dir     = DIR_UP;
            end else if (press[1]) begin
                ev_dir_vld = 1'b1;
                ev_dir     = DIR_DOWN;
            end else if (press[2]) begin
                ev_dir_vld = 1'b1;
                ev_dir     = DIR_LEFT;
            end else if (press[3]) begin
                ev_dir_vld = 1'b1;
                ev_dir     = DIR_RIGHT;
            end
        end
    end

    logic [3:0] step_x, step_y;
    logic       step_ok;
    logic [2:0] land_x, land_y;
    always_comb begin
        step_x = {1'b0, cur_x_q};
        step_y = {1'b0, cur_y_q};
        land_x = cur_x_q;
        land_y = cur_y_q;
        unique case (ev_dir)
            DIR_LEFT:  step_x = step_x - 4'd1;
            DIR_RIGHT: step_x = step_x + 4'd1;
            DIR_UP:    step_y = step_y - 4'd1;
            DIR_DOWN:  step_y = step_y + 4'd1;
        endcase
        unique case (dir_q)
            DIR_LEFT:  land_x = cur_x_q - 3'd2;
            DIR_RIGHT: land_x = cur_x_q + 3'd2;
            DIR_UP:    land_y = cur_y_q - 3'd2;
            DIR_DOWN:  land_y = cur_y_q + 3'd2;
        endcase
        // Underflow wraps to 15, so the range check also rejects steps off the low edge.
        step_ok = (step_x < 4'(BOARD_WIDTH)) && (step_y < 4'(BOARD_WIDTH))
                  && space_exists(step_x, step_y);
    end

    always_comb begin
        state_d   = state_q;
        cur_x_d   = cur_x_q;
        cur_y_d   = cur_y_q;
        dir_d     = dir_q;
        cap_d     = cap_q;
        total_d   = total_q;
        ok_d      = 1'b0;
        bad_d     = 1'b0;
        restart_d = 1'b0;
        unique case (state_q)
            StNav: begin
                if (ev_sel) begin
                    state_d = StArmed;
                end else if (ev_dir_vld) begin
                    if (step_ok) begin
                        cur_x_d = step_x[2:0];
                        cur_y_d = step_y[2:0];
                    end
                end else if (game_over) begin
                    state_d = StOver;
                end
            end
            StArmed: begin
                if (ev_sel) begin
                    state_d = StNav;
                end else if (ev_dir_vld) begin
                    dir_d   = ev_dir;
                    cap_d   = piece_count;
                    state_d = StIssue;
                end
            end
            StIssue: state_d = StCheck;
            StCheck: begin
                state_d = StNav;
                if (piece_count == cap_q - 6'd1) begin
                    ok_d    = 1'b1;
                    cur_x_d = land_x;
                    cur_y_d = land_y;
                    if (total_q != 5'd31) begin
                        total_d = total_q + 5'd1;
                    end
                end else begin
                    bad_d = 1'b1;
                end
            end
            StOver: begin
                restart_d = ev_sel;
                if (!game_over) begin
                    state_d = StNav;
                    cur_x_d = CENTRE;
                    cur_y_d = CENTRE;
                    total_d = '0;
                end
            end
            default: state_d = StNav;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StNav;
            cur_x_q   <= CENTRE;
            cur_y_q   <= CENTRE;
            dir_q     <= DIR_LEFT;
            cap_q     <= '0;
            total_q   <= '0;
            ok_q      <= 1'b0;
            bad_q     <= 1'b0;
            restart_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cur_x_q   <= cur_x_d;
            cur_y_q   <= cur_y_d;
            dir_q     <= dir_d;
            cap_q     <= cap_d;
            total_q   <= total_d;
            ok_q      <= ok_d;
            bad_q     <= bad_d;
            restart_q <= restart_d;
        end
    end

    // Requests park on the nonexistent corner (0,0) whenever no move is being issued.
    assign piece_x     = (state_q == StIssue) ? cur_x_q : 3'd0;
    assign piece_y     = (state_q == StIssue) ? cur_y_q : 3'd0;
    assign direction   = (state_q == StIssue) ? dir_q : DIR_LEFT;
    assign cursor_x    = cur_x_q;
    assign cursor_y    = cur_y_q;
    assign armed       = (state_q == StArmed);
    assign over        = (state_q == StOver);
    assign move_ok     = ok_q;
    assign move_bad    = bad_q;
    assign move_total  = total_q;
    assign restart_req = restart_q;

endmodule
